pc_sequencer: RTL and testbench

Multicycle control FSM that sequences instruction execution around the 6-bit program counter. It fetches each instruction over an instruction-memory request/acknowledge handshake and latches it. It decodes the opcode and drives the PC's halt/branch/jump/immBranch/jumpAddr inputs, plus datapath enables. It sits between the PC, instruction memory, data memory and register file. It decides when the PC advances; the PC itself does not.

---
 rtl/pc_sequencer.sv | 147 ++++++++++++++
 tb/tb_pc_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Multicycle fetch/decode/execute control FSM that decides when the 6-bit PC advances.
// Control outputs are decoded from the current state, the latched instruction and the memory acks.
module pc_sequencer #(
    parameter int TIMEOUT = 15,
    parameter int IW      = 16
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic          start,
    output logic          imemReq,
    input  logic          imemAck,
    input  logic [IW-1:0] imemData,
    output logic          dmemReq,
    output logic          dmemWe,
    input  logic          dmemAck,
    output logic [IW-1:0] ir,
    output logic          pcHalt,
    output logic          branch,
    output logic          jump,
    output logic [5:0]    immBranch,
    output logic [5:0]    jumpAddr,
    output logic [2:0]    aluOp,
    output logic          regWrite,
    output logic          running,
    output logic          halted,
    output logic          error
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALTED = 3'd6;
    localparam logic [2:0] S_ERROR  = 3'd7;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LW   = 4'h6;
    localparam logic [3:0] OP_SW   = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_J    = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    logic [2:0]    r_state;
    logic [2:0]    w_state_next;
    logic [IW-1:0] r_ir;
    logic [7:0]    r_cnt;
    logic [7:0]    w_cnt_next;
    logic [3:0]    w_op;
    logic          w_illegal;
    logic          w_expired;
    logic          w_wait_ack;
    logic          w_commit;

    assign w_op       = r_ir[15:12];
    assign w_illegal  = (w_op >= 4'hA) && (w_op <= 4'hE);
    assign w_expired  = (r_cnt >= TIMEOUT_CNT);
    // An ack in the cycle the counter reaches TIMEOUT still wins over the timeout.
    assign w_wait_ack = ((r_state == S_FETCH) && imemAck) || ((r_state == S_MEM) && dmemAck);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = 8'd0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH, S_MEM: begin
                if (w_wait_ack) begin
                    if (r_state == S_FETCH) begin
                        w_state_next = S_DECODE;
                    end else if (w_op == OP_SW) begin
                        w_state_next = S_FETCH;
                    end else begin
                        w_state_next = S_WB;
                    end
                end else if (w_expired) begin
                    w_state_next = S_ERROR;
                end else begin
                    w_cnt_next = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
                end
            end
            S_DECODE: begin
                if (w_illegal) begin
                    w_state_next = S_ERROR;
                end else if (w_op == OP_HALT) begin
                    w_state_next = S_HALTED;
                end else begin
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if ((w_op == OP_BEQ) || (w_op == OP_J)) begin
                    w_state_next = S_FETCH;
                end else if ((w_op == OP_LW) || (w_op == OP_SW)) begin
                    w_state_next = S_MEM;
                end else begin
                    w_state_next = S_WB;
                end
            end
            S_WB: begin
                w_state_next = S_FETCH;
            end
            default: begin
                w_state_next = r_state;
            end
        endcase
    end

    // Exactly one of these terms is true once per executed instruction.
    assign w_commit = ((r_state == S_EXEC) && ((w_op == OP_BEQ) || (w_op == OP_J)))
                    || ((r_state == S_MEM) && (w_op == OP_SW) && dmemAck)
                    || (r_state == S_WB);

    assign imemReq   = (r_state == S_FETCH);
    assign dmemReq   = (r_state == S_MEM);
    assign dmemWe    = (r_state == S_MEM) && (w_op == OP_SW);
    assign ir        = r_ir;
    assign pcHalt    = ~w_commit;
    assign branch    = (r_state == S_EXEC) && (w_op == OP_BEQ);
    assign jump      = (r_state == S_EXEC) && (w_op == OP_J);
    assign immBranch = r_ir[5:0];
    assign jumpAddr  = r_ir[5:0];
    assign aluOp     = (r_state == S_EXEC) ? r_ir[14:12] : 3'd0;
    assign regWrite  = (r_state == S_WB) && (w_op != OP_NOP);
    assign running   = (r_state != S_IDLE) && (r_state != S_HALTED) && (r_state != S_ERROR);
    assign halted    = (r_state == S_HALTED);
    assign error     = (r_state == S_ERROR);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= S_IDLE;
            r_ir    <= '0;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if ((r_state == S_FETCH) && imemAck) begin
                r_ir <= imemData;
            end
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: memory responders push the expected commit of every
// fetched instruction; a negedge monitor pops and checks it when the commit cycle appears.
module tb_pc_sequencer;
    localparam int TO = 6;

    logic        clk = 1'b0;
    logic        resetN = 1'b1;
    logic        start = 1'b0;
    logic        imemReq;
    logic        imemAck = 1'b0;
    logic [15:0] imemData = 16'h0000;
    logic        dmemReq;
    logic        dmemWe;
    logic        dmemAck = 1'b0;
    logic [15:0] ir;
    logic        pcHalt;
    logic        branch;
    logic        jump;
    logic [5:0]  immBranch;
    logic [5:0]  jumpAddr;
    logic [2:0]  aluOp;
    logic        regWrite;
    logic        running;
    logic        halted;
    logic        error;

    pc_sequencer #(.TIMEOUT(TO), .IW(16)) dut (
        .clk(clk), .resetN(resetN), .start(start),
        .imemReq(imemReq), .imemAck(imemAck), .imemData(imemData),
        .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAck(dmemAck),
        .ir(ir), .pcHalt(pcHalt), .branch(branch), .jump(jump),
        .immBranch(immBranch), .jumpAddr(jumpAddr), .aluOp(aluOp),
        .regWrite(regWrite), .running(running), .halted(halted), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        int          ack_cyc;
        int          lat;
        logic        br;
        logic        jmp;
        logic        rw;
        logic        we;
        logic [5:0]  npc;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] imem [64];
    logic        zero_tab [64];
    int          dwait_tab [64];
    int          imem_wait = 0;
    logic [5:0]  pc;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          i_cnt = 0;
    int          d_cnt = 0;
    int          halt_ack_cyc = 0;
    int          ill_ack_cyc = 0;
    bit          ill_pend = 0;
    int          n_commit = 0;
    int          n_imreq = 0;
    int          n_dmreq = 0;
    bit          halt_seen = 0;
    bit          err_seen = 0;
    bit          pc_pending = 0;
    logic [5:0]  pc_exp = 6'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Program counter the sequencer controls; advances only on commit.
    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pc <= 6'd0;
        end else if (!pcHalt) begin
            if (jump) pc <= jumpAddr;
            else if (branch && zero_tab[pc]) pc <= pc + 6'd1 + immBranch;
            else pc <= pc + 6'd1;
        end
    end

    // Instruction memory responder; pushes the expected outcome when it acks a fetch.
    always @(posedge clk) begin
        logic [15:0] w;
        exp_t        e;
        #1;
        if (!resetN) begin
            imemAck = 1'b0;
            i_cnt = 0;
            ill_pend = 0;
        end else if (imemReq) begin
            if (i_cnt == imem_wait) begin
                w = imem[pc];
                imemAck = 1'b1;
                imemData = w;
                i_cnt = 0;
                e.instr = w; e.ack_cyc = cyc; e.lat = 3;
                e.br = 1'b0; e.jmp = 1'b0; e.rw = 1'b0; e.we = 1'b0;
                e.npc = pc + 6'd1;
                case (w[15:12])
                    4'h0: begin end
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5: e.rw = 1'b1;
                    4'h6: begin e.lat = 4 + dwait_tab[pc]; e.rw = 1'b1; end
                    4'h7: begin e.lat = 3 + dwait_tab[pc]; e.we = 1'b1; end
                    4'h8: begin
                        e.lat = 2; e.br = 1'b1;
                        if (zero_tab[pc]) e.npc = pc + 6'd1 + w[5:0];
                    end
                    4'h9: begin e.lat = 2; e.jmp = 1'b1; e.npc = w[5:0]; end
                    4'hF: halt_ack_cyc = cyc;
                    default: begin ill_ack_cyc = cyc; ill_pend = 1; end
                endcase
                if ((w[15:12] <= 4'h9)) exp_q.push_back(e);
            end else begin
                imemAck = 1'b0;
                imemData = 16'hDEAD;
                i_cnt++;
            end
        end else begin
            imemAck = 1'b0;
            i_cnt = 0;
        end
    end

    // Data memory responder with a per-address wait count.
    always @(posedge clk) begin
        #1;
        if (resetN && dmemReq) begin
            dmemAck = (d_cnt == dwait_tab[pc]);
            d_cnt = dmemAck ? 0 : d_cnt + 1;
        end else begin
            dmemAck = 1'b0;
            d_cnt = 0;
        end
    end

    // Monitor: pops the scoreboard on each commit cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!resetN) begin
            exp_q.delete();
            n_commit = 0; n_imreq = 0; n_dmreq = 0;
            halt_seen = 0; err_seen = 0; pc_pending = 0;
        end else begin
            if (imemReq) n_imreq++;
            if (dmemReq) n_dmreq++;
            if (exp_q.size() > 0) begin
                if (cyc == exp_q[0].ack_cyc + 2) check("exec_aluOp", aluOp, exp_q[0].instr[14:12]);
                if (dmemReq) check("dmemWe", dmemWe, exp_q[0].we);
            end
            if (pc_pending) begin
                check("pc_next", pc, pc_exp);
                check("refetch", imemReq, 1);
                pc_pending = 0;
            end
            if (!pcHalt) begin
                n_commit++;
                if (exp_q.size() == 0) begin
                    check("commit_unexpected", pcHalt, 1);
                end else begin
                    e = exp_q.pop_front();
                    $display("commit: ir=%04h lat=%0d pc_next=%02h", e.instr, cyc - e.ack_cyc, e.npc);
                    check("commit_lat", cyc - e.ack_cyc, e.lat);
                    check("branch", branch, e.br);
                    check("jump", jump, e.jmp);
                    check("regWrite", regWrite, e.rw);
                    check("ir", ir, e.instr);
                    check("aluOp_commit", aluOp, (e.br || e.jmp) ? e.instr[14:12] : 3'd0);
                    check("immBranch", immBranch, e.instr[5:0]);
                    check("running", running, 1);
                    if (e.we) check("dmemWe_commit", dmemWe, 1);
                    pc_pending = 1;
                    pc_exp = e.npc;
                end
            end
            if (halted && !halt_seen) begin
                halt_seen = 1;
                check("halt_lat", cyc - halt_ack_cyc, 2);
            end
            if (error && !err_seen) begin
                err_seen = 1;
                if (ill_pend) check("illegal_lat", cyc - ill_ack_cyc, 2);
            end
        end
        cyc++;
    end

    task automatic load_defaults();
        for (int a = 0; a < 64; a++) begin
            imem[a] = 16'hF000;
            zero_tab[a] = 1'b0;
            dwait_tab[a] = 0;
        end
        imem_wait = 0;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetN = 1'b1;
    endtask

    task automatic wait_error(input string tag);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (error) break;
        end
        check(tag, error, 1);
    endtask

    task automatic check_dead(input string tag);
        repeat (3) begin
            @(posedge clk); #1;
            check({tag, "_imemReq"}, imemReq, 0);
            check({tag, "_dmemReq"}, dmemReq, 0);
            check({tag, "_pcHalt"}, pcHalt, 1);
            check({tag, "_running"}, running, 0);
        end
    endtask

    initial begin
        load_defaults();
        #2 resetN = 1'b0;
        #1;
        check("rst_pcHalt", pcHalt, 1);
        check("rst_halted", halted, 0);
        check("rst_error", error, 0);
        check("rst_imemReq", imemReq, 0);
        check("rst_ir", ir, 0);
        check("rst_running", running, 0);
        repeat (2) @(posedge clk);
        #1 resetN = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_imemReq", imemReq, 0);
        check("idle_running", running, 0);

        // Program 1: every instruction class, ending in HALT.
        imem[6'h00] = 16'h1000;
        imem[6'h01] = 16'h8003; zero_tab[6'h01] = 1'b1;
        imem[6'h05] = 16'h9015;
        imem[6'h15] = 16'h2000;
        imem[6'h16] = 16'h6000; dwait_tab[6'h16] = 5;
        imem[6'h17] = 16'h7000; dwait_tab[6'h17] = 2;
        imem[6'h18] = 16'h0000;
        imem[6'h19] = 16'h5000;
        imem[6'h1A] = 16'h8007;
        imem[6'h1B] = 16'hF000;
        start = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (halted) break;
        end
        check("p1_halted", halted, 1);
        check("p1_commits", n_commit, 9);
        check("p1_queue_empty", exp_q.size(), 0);
        repeat (5) begin
            @(posedge clk); #1;
            check("p1_hold_pcHalt", pcHalt, 1);
            check("p1_hold_halted", halted, 1);
            check("p1_hold_imemReq", imemReq, 0);
            check("p1_hold_pc", pc, 6'h1B);
            check("p1_hold_error", error, 0);
        end

        // Program 2: late acks on both memories, then an illegal opcode.
        do_reset();
        load_defaults();
        imem[0] = 16'h6000; dwait_tab[0] = TO;
        imem[1] = 16'hB000;
        imem_wait = TO;
        start = 1'b1;
        wait_error("p2_error");
        check("p2_halted", halted, 0);
        check("p2_pc", pc, 1);
        check("p2_commits", n_commit, 1);
        check_dead("p2_dead");

        // Program 3: data memory never acks in time; SW must not commit.
        do_reset();
        load_defaults();
        imem[0] = 16'h1000;
        imem[1] = 16'h7000; dwait_tab[1] = TO + 1;
        start = 1'b1;
        wait_error("p3_error");
        check("p3_dmemReq_cycles", n_dmreq, TO + 1);
        check("p3_pc", pc, 1);
        check("p3_commits", n_commit, 1);
        check("p3_sw_pending", exp_q.size(), 1);
        check_dead("p3_dead");

        // Program 4: fetch timeout.
        do_reset();
        load_defaults();
        imem_wait = TO + 1;
        start = 1'b1;
        wait_error("p4_error");
        check("p4_imemReq_cycles", n_imreq, TO + 1);
        check("p4_pc", pc, 0);
        check("p4_commits", n_commit, 0);

        // Program 5: asynchronous reset in the middle of a load.
        do_reset();
        load_defaults();
        imem[0] = 16'h6000; dwait_tab[0] = 20;
        start = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (dmemReq) break;
        end
        check("p5_in_mem", dmemReq, 1);
        repeat (2) @(posedge clk);
        #3 resetN = 1'b0;
        #1;
        check("p5_rst_dmemReq", dmemReq, 0);
        check("p5_rst_pcHalt", pcHalt, 1);
        check("p5_rst_running", running, 0);
        check("p5_rst_ir", ir, 0);
        check("p5_rst_regWrite", regWrite, 0);
        start = 1'b0;
        @(posedge clk);
        #1 resetN = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check("p5_idle_imemReq", imemReq, 0);
            check("p5_idle_running", running, 0);
        end
        check("p5_pc", pc, 0);
        check("p5_commits", n_commit, 0);
        start = 1'b1;
        @(posedge clk); #1;
        check("p5_restart", imemReq, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
